// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with a blocking miss/refill controller.
// Hits return one cycle after lookup; a miss stalls fetch until the refilled line is replayed.
module icache_dm_refill #(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_fetch_en,
  input  logic [31:0]         i_address,
  input  logic                i_flush,
  output logic [31:0]         o_inst,
  output logic                o_hit,
  output logic                o_stall,
  output logic                o_mem_req,
  output logic [31:0]         o_mem_addr,
  input  logic                i_mem_ack,
  input  logic [32*WORDS-1:0] i_mem_data,
  output logic [31:0]         o_hit_count,
  output logic [31:0]         o_miss_count
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int OFF_S = (OFF_W > 0) ? OFF_W : 1;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << (OFF_W + 2)) - 32'd1);

  typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

  state_t              r_state;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [32*WORDS-1:0] r_data [LINES];
  logic [31:0]         r_addr;
  logic [31:0]         r_inst;
  logic                r_hit;
  logic                r_stall;
  logic                r_mem_req;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_hit_count;
  logic [31:0]         r_miss_count;

  function automatic logic [IDX_W-1:0] f_idx(input logic [31:0] a);
    return a[IDX_W+OFF_W+1:OFF_W+2];
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(input logic [31:0] a);
    return a[31:IDX_W+OFF_W+2];
  endfunction

  // With a single word per line the offset field is empty; the mask forces it to zero.
  function automatic logic [OFF_S-1:0] f_off(input logic [31:0] a);
    return OFF_S'(a >> 2) & OFF_S'(WORDS - 1);
  endfunction

  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_ridx;
  logic [32*WORDS-1:0] w_line;
  logic [32*WORDS-1:0] w_rline;
  logic [31:0]         w_word;
  logic [31:0]         w_rword;
  logic                w_lookup_hit;
  logic                w_fill;

  assign w_idx        = f_idx(i_address);
  assign w_ridx       = f_idx(r_addr);
  assign w_line       = r_data[w_idx];
  assign w_rline      = r_data[w_ridx];
  assign w_word       = w_line[{f_off(i_address), 5'd0} +: 32];
  assign w_rword      = w_rline[{f_off(r_addr), 5'd0} +: 32];
  assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == f_tag(i_address));
  assign w_fill       = (r_state == MISS) && i_mem_ack;

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge i_clk) begin
    if (w_fill) begin
      r_tag[w_ridx]  <= f_tag(r_addr);
      r_data[w_ridx] <= i_mem_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_addr       <= '0;
      r_inst       <= '0;
      r_hit        <= 1'b0;
      r_stall      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_flush) begin
            r_valid <= '0;
            r_hit   <= 1'b0;
          end else if (!i_fetch_en) begin
            r_hit <= 1'b0;
          end else if (w_lookup_hit) begin
            r_inst <= w_word;
            r_hit  <= 1'b1;
            if (r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
          end else begin
            r_hit      <= 1'b0;
            r_stall    <= 1'b1;
            r_mem_req  <= 1'b1;
            r_mem_addr <= i_address & LINE_MASK;
            r_addr     <= i_address;
            if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
            r_state    <= MISS;
          end
        end
        MISS: begin
          // A flush coinciding with the ack still leaves the refilled line valid.
          if (i_flush)
            r_valid <= w_fill ? (LINES'(1) << w_ridx) : '0;
          else if (w_fill)
            r_valid[w_ridx] <= 1'b1;
          if (w_fill) begin
            r_mem_req <= 1'b0;
            r_state   <= FILL;
          end
        end
        FILL: begin
          if (i_flush) r_valid <= '0;
          r_inst  <= w_rword;
          r_hit   <= 1'b1;
          r_stall <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_inst       = r_inst;
  assign o_hit        = r_hit;
  assign o_stall      = r_stall;
  assign o_mem_req    = r_mem_req;
  assign o_mem_addr   = r_mem_addr;
  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_dm_refill.sv
// Scenario bench for icache_dm_refill (LINES=8, WORDS=4): expected instructions are queued
// from a small memory model at fetch time and popped when the cache reports a hit.
module tb_icache_dm_refill;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         fetch_en = 1'b0;
  logic         flush = 1'b0;
  logic         mem_ack = 1'b0;
  logic [31:0]  address = '0;
  logic [127:0] mem_data = '0;
  logic [31:0]  inst, mem_addr, hit_count, miss_count;
  logic         hit, stall, mem_req;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_hits = '0;
  logic [31:0] exp_miss = '0;
  logic [31:0] got;

  always #5 clk = ~clk;

  icache_dm_refill #(.LINES(8), .WORDS(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fetch_en(fetch_en), .i_address(address),
    .i_flush(flush), .o_inst(inst), .o_hit(hit), .o_stall(stall),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
    .i_mem_data(mem_data), .o_hit_count(hit_count), .o_miss_count(miss_count)
  );

  // Memory model: line 0x40 holds the reference pattern, everything else an address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = (a >> 2) & 32'd3;
    if ((a & ~32'hF) == 32'h40) return 32'h1111 * (k + 32'd1);
    return (a & ~32'h3) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(base + 32'(4 * k));
    return l;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_en = 1'b1;
    address  = a;
    exp_q.push_back(mem_word(a));
  endtask

  // Full miss scenario: request, ack at the next edge, replay one edge later.
  task automatic run_miss(input logic [31:0] a, input string nm);
    fetch(a);
    exp_miss = sat_inc(exp_miss);
    cyc();
    n_cmp++;
    if ({stall, mem_req, hit, mem_addr} !== {3'b110, a & ~32'hF}) begin
      n_bad++;
      $display("FAIL %s_req: got stall/req/hit/addr=%b/%b/%b/%h want 1/1/0/%h",
               nm, stall, mem_req, hit, mem_addr, a & ~32'hF);
    end
    fetch_en = 1'b0;
    mem_ack  = 1'b1;
    mem_data = mem_line(mem_addr);
    cyc();
    mem_ack = 1'b0;
    n_cmp++;
    if ({stall, mem_req, hit} !== 3'b100) begin
      n_bad++;
      $display("FAIL %s_ack: got stall/req/hit=%b/%b/%b want 1/0/0", nm, stall, mem_req, hit);
    end
    cyc();
    got = exp_q.pop_front();
    n_cmp++;
    if ({stall, hit, inst, miss_count} !== {2'b01, got, exp_miss}) begin
      n_bad++;
      $display("FAIL %s_fill: got stall/hit/inst/miss=%b/%b/%h/%0d want 0/1/%h/%0d",
               nm, stall, hit, inst, miss_count, got, exp_miss);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({inst, hit, stall, mem_req, mem_addr, hit_count, miss_count} !== '0) begin
      n_bad++;
      $display("FAIL reset: got inst=%h hit=%b stall=%b req=%b addr=%h hc=%0d mc=%0d want all 0",
               inst, hit, stall, mem_req, mem_addr, hit_count, miss_count);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_miss_fill();
    run_miss(32'h40, "first_miss");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      fetch(32'h44 + 32'(4 * i));
      exp_hits = sat_inc(exp_hits);
      cyc();
      got = exp_q.pop_front();
      n_cmp++;
      if ({stall, hit, inst, hit_count} !== {2'b01, got, exp_hits}) begin
        n_bad++;
        $display("FAIL b2b_%0d: got stall/hit/inst/hc=%b/%b/%h/%0d want 0/1/%h/%0d",
                 i, stall, hit, inst, hit_count, got, exp_hits);
      end
    end
    fetch_en = 1'b0;
    cyc();
    n_cmp++;
    if ({hit, inst} !== {1'b0, 32'h4444}) begin
      n_bad++;
      $display("FAIL idle_hold: got hit/inst=%b/%h want 0/00004444", hit, inst);
    end
  endtask

  task automatic test_conflict();
    run_miss(32'hC0, "conflict_c0");
    run_miss(32'h40, "conflict_40");
  endtask

  task automatic test_delayed_ack();
    fetch(32'h104);
    exp_miss = sat_inc(exp_miss);
    cyc();
    for (int i = 0; i < 10; i++) begin
      fetch_en = 1'($urandom_range(0, 1));
      address  = $urandom;
      cyc();
      n_cmp++;
      if ({stall, mem_req, hit, mem_addr} !== {3'b110, 32'h100}) begin
        n_bad++;
        $display("FAIL delay_hold_%0d: got stall/req/hit/addr=%b/%b/%b/%h want 1/1/0/00000100",
                 i, stall, mem_req, hit, mem_addr);
      end
    end
    fetch_en = 1'b0;
    mem_ack  = 1'b1;
    mem_data = mem_line(mem_addr);
    cyc();
    mem_ack = 1'b0;
    cyc();
    got = exp_q.pop_front();
    n_cmp++;
    if ({stall, hit, inst, miss_count} !== {2'b01, got, exp_miss}) begin
      n_bad++;
      $display("FAIL delay_fill: got stall/hit/inst/miss=%b/%b/%h/%0d want 0/1/%h/%0d",
               stall, hit, inst, miss_count, got, exp_miss);
    end
  endtask

  task automatic test_flush();
    run_miss(32'h00, "fl_line0");
    run_miss(32'h10, "fl_line1");
    fetch(32'h04);
    exp_hits = sat_inc(exp_hits);
    cyc();
    got = exp_q.pop_front();
    n_cmp++;
    if ({hit, inst} !== {1'b1, got}) begin
      n_bad++;
      $display("FAIL prefl_hit: got hit/inst=%b/%h want 1/%h", hit, inst, got);
    end
    fetch_en = 1'b1;
    address  = 32'h04;
    flush    = 1'b1;
    cyc();
    flush    = 1'b0;
    fetch_en = 1'b0;
    n_cmp++;
    if ({hit, stall, hit_count} !== {2'b00, exp_hits}) begin
      n_bad++;
      $display("FAIL flush_prio: got hit/stall/hc=%b/%b/%0d want 0/0/%0d",
               hit, stall, hit_count, exp_hits);
    end
    run_miss(32'h04, "postfl_line0");
    run_miss(32'h18, "postfl_line1");
  endtask

  task automatic test_flush_with_ack();
    fetch(32'h28);
    exp_miss = sat_inc(exp_miss);
    cyc();
    fetch_en = 1'b0;
    flush    = 1'b1;
    mem_ack  = 1'b1;
    mem_data = mem_line(mem_addr);
    cyc();
    flush   = 1'b0;
    mem_ack = 1'b0;
    cyc();
    got = exp_q.pop_front();
    n_cmp++;
    if ({stall, hit, inst} !== {2'b01, got}) begin
      n_bad++;
      $display("FAIL flushack_fill: got stall/hit/inst=%b/%b/%h want 0/1/%h", stall, hit, inst, got);
    end
    fetch(32'h2C);
    exp_hits = sat_inc(exp_hits);
    cyc();
    fetch_en = 1'b0;
    got = exp_q.pop_front();
    n_cmp++;
    if ({stall, hit, inst, hit_count} !== {2'b01, got, exp_hits}) begin
      n_bad++;
      $display("FAIL flushack_keep: got stall/hit/inst/hc=%b/%b/%h/%0d want 0/1/%h/%0d",
               stall, hit, inst, hit_count, got, exp_hits);
    end
    run_miss(32'h18, "flushack_other");
  endtask

  task automatic test_saturation();
    run_miss(32'h48, "sat_fill");
    force dut.r_hit_count = 32'hFFFF_FFFE;
    cyc();
    release dut.r_hit_count;
    exp_hits = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      fetch(32'h40 + 32'(4 * i));
      exp_hits = sat_inc(exp_hits);
      cyc();
      got = exp_q.pop_front();
      n_cmp++;
      if ({hit, inst, hit_count} !== {1'b1, got, exp_hits}) begin
        n_bad++;
        $display("FAIL sat_%0d: got hit/inst/hc=%b/%h/%h want 1/%h/%h",
                 i, hit, inst, hit_count, got, exp_hits);
      end
    end
    fetch_en = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_miss();
    fetch_en = 1'b1;
    address  = 32'h200;
    cyc();
    fetch_en = 1'b0;
    n_cmp++;
    if ({stall, mem_req} !== 2'b11) begin
      n_bad++;
      $display("FAIL rstmiss_pre: got stall/req=%b/%b want 1/1", stall, mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, stall, hit, hit_count, miss_count} !== '0) begin
      n_bad++;
      $display("FAIL rstmiss_async: got req/stall/hit/hc/mc=%b/%b/%b/%0d/%0d want 0/0/0/0/0",
               mem_req, stall, hit, hit_count, miss_count);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    mem_ack  = 1'b1;
    mem_data = mem_line(32'h200);
    cyc();
    mem_ack = 1'b0;
    cyc();
    n_cmp++;
    if ({mem_req, stall, hit, inst} !== '0) begin
      n_bad++;
      $display("FAIL late_ack: got req/stall/hit/inst=%b/%b/%b/%h want 0/0/0/0", mem_req, stall, hit, inst);
    end
    exp_hits = '0;
    exp_miss = '0;
    run_miss(32'h40, "post_reset");
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_back_to_back();
    test_conflict();
    test_delayed_ack();
    test_flush();
    test_flush_with_ack();
    test_saturation();
    test_reset_mid_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_dm_refill.md
# icache_dm_refill

Parametrised direct-mapped instruction cache with an integrated miss/refill controller, placed between the fetch stage and the instruction memory. It generalises the fixed 8-line, 4-word cache to configurable depth and line size. It adds a valid-bit reset and flush, a request/acknowledge refill handshake with fetch stall, and saturating hit/miss counters. Hits return the instruction one clock after the address is sampled. Misses stall fetch until the line has been fetched and written.

## Interface
- LINES, 8, number of cache lines; power of two, >= 2
- WORDS, 4, 32-bit words per line; power of two, >= 1
- Derived: OFF_W = log2(WORDS), IDX_W = log2(LINES), TAG_W = 30 - OFF_W - IDX_W
- Address split: byte bits [1:0] ignored; word offset [OFF_W+1:2]; index [IDX_W+OFF_W+1:OFF_W+2]; tag [31:IDX_W+OFF_W+2]

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  lookup request for `address` this cycle
- address  in  32  fetch byte address
- flush  in  1  invalidate all lines
- inst  out  32  instruction read
- hit  out  1  `inst` is valid this cycle
- stall  out  1  refill in progress; fetch must hold `address`
- mem_req  out  1  refill request
- mem_addr  out  32  line-aligned refill address; low OFF_W+2 bits are zero
- mem_ack  in  1  `mem_data` is valid; one-cycle pulse
- mem_data  in  32*WORDS  full line; word k is at bits [32k+31:32k]
- hit_count  out  32  saturating count of hits
- miss_count  out  32  saturating count of misses

## Operation
- Storage per line: valid bit, TAG_W tag, 32*WORDS data.
- Reset state:
  - all valid bits = 0, state IDLE
  - inst = 0, hit = 0, stall = 0, mem_req = 0, mem_addr = 0
  - both counters = 0
  - data and tag arrays are not cleared.
- FSM states: IDLE, MISS, FILL.
- IDLE, on each rising edge:
  - If flush = 1: clear all valid bits, hit <= 0, no lookup, stay IDLE. flush has priority over fetch_en.
  - Else if fetch_en = 0: hit <= 0, inst holds its value, stay IDLE.
  - Else if the indexed line is valid and its tag matches: inst <= selected word, hit <= 1, hit_count += 1.
  - Else (miss):
    - hit <= 0, stall <= 1, mem_req <= 1
    - mem_addr <= {address[31:OFF_W+2], 0}
    - latch address internally, miss_count += 1, go to MISS.
- MISS:
  - Hold mem_req and mem_addr stable.
  - `address` and fetch_en are ignored; the latched address is used.
  - On mem_ack = 1: write mem_data, tag and valid = 1 into the latched index; mem_req <= 0; go to FILL.
- FILL, one cycle:
  - Re-read the latched address: inst <= word, hit <= 1, stall <= 0, go to IDLE.
  - The replay does not increment hit_count.
- flush in MISS or FILL:
  - Clears all valid bits at that edge.
  - The in-flight refill still completes, writes its line as valid and delivers hit = 1 in FILL.
  - If flush and mem_ack fall on the same edge, the line write wins for that index.
- mem_ack outside MISS is ignored.
- Counters saturate at 32'hFFFF_FFFF and never wrap.

## Timing
- Hit: address sampled at edge N; inst and hit are valid after edge N, i.e. 1-cycle latency. Back-to-back hits run at one per cycle.
- Miss: miss detected at edge N, so stall and mem_req are high after N. With mem_ack sampled at edge M > N:
  - mem_req low after M
  - inst, hit = 1 and stall = 0 after M+1
- Minimum miss penalty: 3 cycles, with mem_ack at N+1.
- hit is a 1-cycle indication per lookup. It is 0 whenever stall = 1.
- Asynchronous reset mid-refill:
  - mem_req, stall and hit drop immediately and the FSM returns to IDLE.
  - The memory side must tolerate an abandoned request; a later mem_ack is ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then fetch 0x40 -> miss, mem_addr = 0x40, stall = 1. Ack with line {0x4444,0x3333,0x2222,0x1111} at N+1 -> one cycle later inst = 0x1111, hit = 1, miss_count = 1.
- After the fill, fetch 0x44, 0x48, 0x4C on consecutive cycles -> inst = 0x2222, 0x3333, 0x4444 each one cycle later, hit = 1, hit_count = 3, no stall.
- Conflict: fill 0x40, then fetch 0xC0 (same index, LINES = 8, WORDS = 4) -> miss, mem_addr = 0xC0. Refetch 0x40 -> miss again; miss_count increments each time.
- Delayed ack: hold mem_ack = 0 for 10 cycles while changing `address` -> mem_req and mem_addr stay stable, and the latched address is served after the ack.
- Flush after filling lines 0 and 1 -> a hit on the next fetch of either line is impossible (miss). Assert Rst_n = 0 while in MISS -> mem_req = 0 immediately and counters = 0.
- Saturation: preload hit_count to 0xFFFF_FFFE via a long hit run, or force it in the bench -> two more hits leave it at 0xFFFF_FFFF.
